demand_call_manager: RTL and testbench
======================================

# demand_call_manager

Front-end scheduler for the intersection's green time. It sits between the raw detector loops and `traffic_light_controller`. It latches each approach's demand ("call") until that approach has actually been served, and feeds the latched calls to the controller's sensor inputs. It also implements emergency-vehicle preemption: all competing calls are masked so the controller drains to, then holds, the requested approach.

## Interface
Parameters:
- `HOLD_CYC`, default 3: consecutive green cycles on an approach, with its detector low, required to clear its call.
- `PREEMPT_MAX`, default 30: maximum cycles spent in DRAIN+HOLD before a forced release.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it forces all state and outputs to reset values immediately.
- `det_e_str`, `det_w_str`, `det_e_left`, `det_w_left`, `det_ns`  in  1 each  raw detector loops.
- `ev_req`  in  1  emergency-vehicle preemption request, level.
- `ev_dir`  in  3  approach to preempt: 0=e_str, 1=w_str, 2=e_left, 3=w_left, 4=ns; values 5–7 are invalid.
- `e_str_light`, `w_str_light`, `e_left_light`, `w_left_light`, `ns_light`  in  `colors`  light feedback from the controller.
- `e_str_sensor`, `w_str_sensor`, `e_left_sensor`, `w_left_sensor`, `ns_sensor`  out  1 each  to controller sensor inputs, registered.
- `call_pending`  out  5  latched call vector, bit order as `ev_dir`.
- `ev_active`  out  1  high while the FSM is in DRAIN or HOLD.
- `ev_ack`  out  1  high while in HOLD, meaning the preempted approach is green.

## Operation
- **Call latch, per approach i:**
  - Set: `call[i]` ← 1 whenever `det[i]`=1.
  - Dwell counter: `dwell[i]` increments while `light[i]`==green and saturates at `HOLD_CYC`; it clears to 0 whenever `light[i]`≠green.
  - Clear: `call[i]` ← 0 when `dwell[i]`==`HOLD_CYC` and `det[i]`=0.
  - Set wins over clear in the same cycle.
  - `call_pending` = `call`.
- **Normal sensor drive:** `sensor[i]` ← `call[i]`.
- **Preemption FSM**, states IDLE, DRAIN, HOLD, RELEASE:
  - IDLE:
    - On a rising edge of `ev_req` with `ev_dir`≤4: capture `ev_dir` into `pdir`, clear `pctr`, go to DRAIN.
    - If `ev_dir`≥5: ignore the edge and stay in IDLE.
    - A level held high from before does not retrigger; the edge detector is primed only when `ev_req` is seen low.
  - DRAIN:
    - Drive `sensor[pdir]`=1 and all others 0.
    - If `light[pdir]`==green, go to HOLD.
    - If `ev_req`=0, go to RELEASE.
    - If `pctr`==`PREEMPT_MAX`-1, go to RELEASE.
    - Priority of these exits: timeout > `ev_req` drop > green.
  - HOLD:
    - Same sensor masking as DRAIN, which keeps the controller from timing out.
    - Exit to RELEASE when `ev_req`=0 or `pctr`==`PREEMPT_MAX`-1.
  - RELEASE: lasts exactly 1 cycle, drives sensors from `call`, then goes to IDLE.
  - `pctr` increments every cycle in DRAIN and HOLD. Width is clog2(`PREEMPT_MAX`).
- Call latching and clearing continue during preemption, so masked demand is not lost and is reasserted after RELEASE.
- `ev_dir` changes after capture are ignored until the FSM returns to IDLE.

## Timing
- Reset values: all `*_sensor`=0, `call_pending`=0, `ev_active`=0, `ev_ack`=0, FSM=IDLE, all counters 0, edge detector primed.
- Detector latency: detector→`call_pending` takes 1 cycle; detector→sensor takes 1 cycle (sensor and call are registered from the same next-state).
- Preemption latency:
  - `ev_req` rise→`ev_active` and masked sensors: 1 cycle.
  - Green feedback→`ev_ack`: 1 cycle.
- Release: `ev_req` fall in HOLD→RELEASE on the next edge; normal sensors resume one cycle after that.
- Forced release: fires after `PREEMPT_MAX` cycles in DRAIN+HOLD, even if `ev_req` is still high. A new preemption then requires `ev_req` to fall and rise again.
- Reset asserted mid-preempt: immediate return to reset values, and all calls are lost.

## Structure
- The `light_package` gains:
  - `approach_t`: enum E_STR..NS, encoded 0..4.
  - `preempt_state_t`: IDLE, DRAIN, HOLD, RELEASE.
  - Constant `N_APPROACH`=5.
- `colors` is reused unchanged.
- One sub-module, `call_latch`, holds the set/clear logic and dwell counter, is parameterised by `HOLD_CYC`, and is instantiated 5×.
- The top level contains the preemption FSM, `pctr`, the edge detector and the sensor mux.

## Test plan
- `det_ns` pulsed for 1 cycle with all lights red → `call_pending`[4]=1 and `ns_sensor`=1 next cycle. The call holds until `ns_light`=green for 3 cycles with `det_ns`=0, then clears the following cycle.
- `det_e_str` held high while `e_str_light`=green for 10 cycles → the call never clears. Drop the detector → the call clears 1 cycle later.
- `ev_req`=1, `ev_dir`=4 while e_str/w_str calls are pending → `ev_active`=1 next cycle, only `ns_sensor`=1. Drive `ns_light` green → `ev_ack`=1. Drop `ev_req` → RELEASE, then e_str/w_str sensors return to 1.
- `ev_req` held high, `ev_dir`=2, `PREEMPT_MAX`=30, `e_left_light` never green → forced release after 30 cycles, `ev_active`=0. `ev_req` still high → no retrigger until it falls and rises again.
- `ev_dir`=6 with an `ev_req` rise → FSM stays IDLE, `ev_active` remains 0.
- Reset pulled low during HOLD → all outputs 0 asynchronously, before the next `clk` edge. After release, the FSM is IDLE.

Source files
------------

// File: rtl/light_package.sv
// Shared types for the intersection: light colours, approach encoding and
// the preemption FSM states.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;

    localparam int N_APPROACH = 5;

    typedef enum logic [2:0] {
        E_STR  = 3'd0,
        W_STR  = 3'd1,
        E_LEFT = 3'd2,
        W_LEFT = 3'd3,
        NS     = 3'd4
    } approach_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } preempt_state_t;

endpackage

// File: rtl/call_latch.sv
// One approach's demand latch. The call is held until the approach has been
// green for HOLD_CYC cycles with its detector quiet. The next-state value is
// also exported so the top can register sensors in lock-step with the call.
module call_latch
    import light_package::*;
#(
    parameter int HOLD_CYC = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_det,
    input  colors i_light,
    output logic  o_call_d,
    output logic  o_call
);

    localparam int DW_W = $clog2(HOLD_CYC + 1);

    logic [DW_W-1:0] r_dwell;
    logic            r_call;
    logic            w_served;

    assign w_served = (r_dwell == DW_W'(HOLD_CYC));
    // Detector set has priority over the served-clear.
    assign o_call_d = i_det | (r_call & ~w_served);
    assign o_call   = r_call;

    // Dwell counter: count green cycles, saturate, zero on any non-green.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell <= '0;
        end else if (i_light != green) begin
            r_dwell <= '0;
        end else if (!w_served) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Call register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_call <= 1'b0;
        end else begin
            r_call <= o_call_d;
        end
    end

endmodule

// File: rtl/demand_call_manager.sv
// Front-end scheduler between the detector loops and the light controller:
// latches per-approach calls and applies emergency-vehicle preemption by
// masking every sensor except the preempted approach.
module demand_call_manager
    import light_package::*;
#(
    parameter int HOLD_CYC    = 3,
    parameter int PREEMPT_MAX = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_e_str,
    input  logic       det_w_str,
    input  logic       det_e_left,
    input  logic       det_w_left,
    input  logic       det_ns,
    input  logic       ev_req,
    input  logic [2:0] ev_dir,
    input  colors      e_str_light,
    input  colors      w_str_light,
    input  colors      e_left_light,
    input  colors      w_left_light,
    input  colors      ns_light,
    output logic       e_str_sensor,
    output logic       w_str_sensor,
    output logic       e_left_sensor,
    output logic       w_left_sensor,
    output logic       ns_sensor,
    output logic [4:0] call_pending,
    output logic       ev_active,
    output logic       ev_ack
);

    localparam int PW = $clog2(PREEMPT_MAX);

    logic [N_APPROACH-1:0] w_det;
    logic [N_APPROACH-1:0] w_call;
    logic [N_APPROACH-1:0] w_call_d;
    logic [N_APPROACH-1:0] w_sens_d;
    colors                 w_light [N_APPROACH];

    preempt_state_t r_state, w_state_d;
    approach_t      r_pdir, w_pdir_d;
    logic [PW-1:0]  r_pctr;
    logic           r_armed;
    logic [N_APPROACH-1:0] r_sensor;
    logic           w_capture;
    logic           w_timeout;
    logic           w_masked_d;

    assign w_det      = {det_ns, det_w_left, det_e_left, det_w_str, det_e_str};
    assign w_light[0] = e_str_light;
    assign w_light[1] = w_str_light;
    assign w_light[2] = e_left_light;
    assign w_light[3] = w_left_light;
    assign w_light[4] = ns_light;

    for (genvar g = 0; g < N_APPROACH; g++) begin : g_lat
        call_latch #(.HOLD_CYC(HOLD_CYC)) u_latch (
            .clk     (clk),
            .reset   (reset),
            .i_det   (w_det[g]),
            .i_light (w_light[g]),
            .o_call_d(w_call_d[g]),
            .o_call  (w_call[g])
        );
    end

    assign w_capture = (r_state == IDLE) && ev_req && r_armed && (ev_dir <= 3'd4);
    assign w_timeout = (r_pctr == PW'(PREEMPT_MAX - 1));
    assign w_pdir_d  = w_capture ? approach_t'(ev_dir) : r_pdir;

    // Next-state logic for the preemption FSM.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_state_d = DRAIN;
            DRAIN: begin
                if (w_timeout || !ev_req)          w_state_d = RELEASE;
                else if (w_light[r_pdir] == green) w_state_d = HOLD;
            end
            HOLD:    if (w_timeout || !ev_req) w_state_d = RELEASE;
            RELEASE: w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Sensors are registered from the same next-state as the calls, masked
    // to the preempted approach whenever the FSM is heading into DRAIN/HOLD.
    assign w_masked_d = (w_state_d == DRAIN) || (w_state_d == HOLD);
    assign w_sens_d   = w_masked_d ? (N_APPROACH'(1) << w_pdir_d) : w_call_d;

    // FSM state, captured direction, preempt counter, edge detector, sensors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_pdir   <= E_STR;
            r_pctr   <= '0;
            r_armed  <= 1'b1;
            r_sensor <= '0;
        end else begin
            r_state  <= w_state_d;
            r_pdir   <= w_pdir_d;
            r_armed  <= ~ev_req;
            r_sensor <= w_sens_d;
            if (w_capture)
                r_pctr <= '0;
            else if (r_state == DRAIN || r_state == HOLD)
                r_pctr <= r_pctr + 1'b1;
        end
    end

    assign {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor} = r_sensor;
    assign call_pending = w_call;
    assign ev_active    = (r_state == DRAIN) || (r_state == HOLD);
    assign ev_ack       = (r_state == HOLD);

endmodule

// File: tb/tb_demand_call_manager.sv
// Directed bench for demand_call_manager: call latching, dwell clearing,
// preemption with release, forced release, invalid direction, async reset.
module tb_demand_call_manager;
    import light_package::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic det_e_str = 0, det_w_str = 0, det_e_left = 0, det_w_left = 0, det_ns = 0;
    logic ev_req = 0;
    logic [2:0] ev_dir = 3'd0;
    colors e_str_light = red, w_str_light = red, e_left_light = red;
    colors w_left_light = red, ns_light = red;
    logic e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
    logic [4:0] call_pending;
    logic ev_active, ev_ack;
    logic [4:0] sens;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign sens = {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor};

    demand_call_manager #(.HOLD_CYC(3), .PREEMPT_MAX(30)) dut (
        .clk(clk), .reset(reset),
        .det_e_str(det_e_str), .det_w_str(det_w_str), .det_e_left(det_e_left),
        .det_w_left(det_w_left), .det_ns(det_ns),
        .ev_req(ev_req), .ev_dir(ev_dir),
        .e_str_light(e_str_light), .w_str_light(w_str_light),
        .e_left_light(e_left_light), .w_left_light(w_left_light), .ns_light(ns_light),
        .e_str_sensor(e_str_sensor), .w_str_sensor(w_str_sensor),
        .e_left_sensor(e_left_sensor), .w_left_sensor(w_left_sensor), .ns_sensor(ns_sensor),
        .call_pending(call_pending), .ev_active(ev_active), .ev_ack(ev_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_sens", 32'(sens), 32'h0);
        chk("rst_call", 32'(call_pending), 32'h0);
        chk("rst_act", 32'(ev_active), 32'h0);
        chk("rst_ack", 32'(ev_ack), 32'h0);
        reset = 1'b1;
        step();

        // NS call: 1-cycle pulse, then served by 3 green cycles
        det_ns = 1; step(); det_ns = 0;
        chk("ns_call_set", 32'(call_pending), 32'h10);
        chk("ns_sens_set", 32'(sens), 32'h10);
        step();
        chk("ns_call_hold", 32'(call_pending), 32'h10);
        ns_light = green;
        step(3);
        chk("ns_call_dwell3", 32'(call_pending), 32'h10);
        step();
        chk("ns_call_clr", 32'(call_pending), 32'h00);
        chk("ns_sens_clr", 32'(sens), 32'h00);
        ns_light = red;

        // Detector held high keeps the call through a long green
        det_e_str = 1; e_str_light = green;
        step(10);
        chk("estr_held", 32'(call_pending), 32'h01);
        det_e_str = 0; step();
        chk("estr_clr", 32'(call_pending), 32'h00);
        e_str_light = red;

        // Preempt NS with e_str/w_str pending
        det_e_str = 1; det_w_str = 1; step(); det_e_str = 0; det_w_str = 0;
        chk("ew_pending", 32'(call_pending), 32'h03);
        ev_req = 1; ev_dir = 3'd4; step();
        chk("pre_active", 32'(ev_active), 32'h1);
        chk("pre_mask", 32'(sens), 32'h10);
        chk("pre_ack0", 32'(ev_ack), 32'h0);
        chk("pre_calls_kept", 32'(call_pending), 32'h03);
        ns_light = green; step();
        chk("pre_ack", 32'(ev_ack), 32'h1);
        ev_req = 0; step();
        chk("rel_active", 32'(ev_active), 32'h0);
        chk("rel_ack", 32'(ev_ack), 32'h0);
        step();
        chk("rel_sens", 32'(sens), 32'h03);
        ns_light = red;

        // Forced release on e_left that never goes green
        ev_req = 1; ev_dir = 3'd2; step();
        ev_dir = 3'd0;
        chk("frc_active", 32'(ev_active), 32'h1);
        step(29);
        chk("frc_still", 32'(ev_active), 32'h1);
        chk("frc_dir_kept", 32'(sens), 32'h04);
        step();
        chk("frc_release", 32'(ev_active), 32'h0);
        step(3);
        chk("frc_no_retrig", 32'(ev_active), 32'h0);
        chk("frc_sens_back", 32'(sens), 32'h03);
        ev_req = 0; step();
        ev_req = 1; ev_dir = 3'd3; step();
        chk("frc_retrig", 32'(ev_active), 32'h1);
        chk("frc_retrig_sens", 32'(sens), 32'h08);
        ev_req = 0; step(2);

        // Invalid direction is ignored
        ev_req = 1; ev_dir = 3'd6; step();
        chk("bad_dir", 32'(ev_active), 32'h0);
        step();
        chk("bad_dir2", 32'(ev_active), 32'h0);
        chk("bad_dir_sens", 32'(sens), 32'h03);
        ev_req = 0; step();

        // Reset during HOLD
        ev_req = 1; ev_dir = 3'd1; step();
        w_str_light = green; step();
        chk("hold_ack", 32'(ev_ack), 32'h1);
        #2 reset = 1'b0; #1;
        chk("arst_sens", 32'(sens), 32'h0);
        chk("arst_call", 32'(call_pending), 32'h0);
        chk("arst_act", 32'(ev_active), 32'h0);
        chk("arst_ack", 32'(ev_ack), 32'h0);
        ev_req = 0; w_str_light = red;
        step();
        reset = 1'b1; step();
        chk("post_rst_act", 32'(ev_active), 32'h0);
        ev_req = 1; ev_dir = 3'd0; step();
        chk("post_rst_idle", 32'(ev_active), 32'h1);
        chk("post_rst_sens", 32'(sens), 32'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
